// File: rtl/trainer.sv
// trainer: far end of a node handshake chain. Accepts a sample, presents its
// arguments, collects the result, computes the saturated error target-result
// and, in training mode, returns the error and drains the propagated terms.
// Optional statistics counters are built when TRAINER_STATS_EN is defined.
module trainer #(
    parameter int unsigned N = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [N-1:0][7:0]     sample_data,
    input  logic [15:0]           sample_target,
    input  logic                  sample_train,
    output logic                  sample_ready,
    output logic                  train,
    output logic                  argument_valid,
    output logic [N-1:0][7:0]     argument_data,
    input  logic                  argument_ready,
    input  logic                  result_valid,
    input  logic [15:0]           result_data,
    output logic                  result_ready,
    output logic                  error_valid,
    output logic [15:0]           error_data,
    input  logic                  error_ready,
    input  logic                  propagate_valid,
    input  logic [N-1:0][15:0]    propagate_data,
    output logic                  propagate_ready,
    output logic                  done
`ifdef TRAINER_STATS_EN
    ,
    output logic [31:0]           stat_count,
    output logic [31:0]           stat_abs_error
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARG  = 3'd1,
        S_RES  = 3'd2,
        S_ERR  = 3'd3,
        S_PRP  = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        done_d;
    logic [15:0] target_q;
    logic [16:0] diff_c;
    logic [15:0] err_sat_c;
    logic        unused_propagate;

    // Propagated terms are consumed but not needed here.
    assign unused_propagate = ^propagate_data;

    // 17-bit difference saturated back into the 16-bit signed range.
    always_comb begin
        diff_c = {target_q[15], target_q} - {result_data[15], result_data};
        if (diff_c[16] != diff_c[15]) begin
            err_sat_c = diff_c[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            err_sat_c = diff_c[15:0];
        end
    end

    // Next-state and completion decode.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (sample_valid) state_d = S_ARG;
            S_ARG:  if (argument_ready) state_d = S_RES;
            S_RES: begin
                if (result_valid) begin
                    if (train) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_ERR:  if (error_ready) state_d = S_PRP;
            S_PRP: begin
                if (propagate_valid) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with handshake outputs registered from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            sample_ready    <= 1'b1;
            argument_valid  <= 1'b0;
            result_ready    <= 1'b0;
            error_valid     <= 1'b0;
            propagate_ready <= 1'b0;
            done            <= 1'b0;
        end else begin
            state_q         <= state_d;
            sample_ready    <= (state_d == S_IDLE);
            argument_valid  <= (state_d == S_ARG);
            result_ready    <= (state_d == S_RES);
            error_valid     <= (state_d == S_ERR);
            propagate_ready <= (state_d == S_PRP);
            done            <= done_d;
        end
    end

    // Sample latch on acceptance, error capture on the result handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            train         <= 1'b0;
            argument_data <= '0;
            target_q      <= 16'd0;
            error_data    <= 16'd0;
        end else begin
            if (state_q == S_IDLE && sample_valid) begin
                train         <= sample_train;
                argument_data <= sample_data;
                target_q      <= sample_target;
            end
            if (state_q == S_RES && result_valid) begin
                error_data <= err_sat_c;
            end
        end
    end

`ifdef TRAINER_STATS_EN
    logic [16:0] err_ext_c;
    logic [16:0] abs_c;
    logic [32:0] sum_c;

    // Magnitude of the saturated error; -32768 yields 32768.
    always_comb begin
        err_ext_c = {err_sat_c[15], err_sat_c};
        abs_c     = err_ext_c[16] ? (17'd0 - err_ext_c) : err_ext_c;
        sum_c     = {1'b0, stat_abs_error} + 33'(abs_c);
    end

    // Transaction count wraps; absolute error sum saturates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_count     <= 32'd0;
            stat_abs_error <= 32'd0;
        end else begin
            if (done_d) begin
                stat_count <= stat_count + 32'd1;
            end
            if (state_q == S_RES && result_valid) begin
                stat_abs_error <= sum_c[32] ? 32'hFFFF_FFFF : sum_c[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_trainer.sv
// Self-checking bench for trainer: directed scenarios plus randomized
// transactions checked against a behavioural model of the error arithmetic,
// handshake sequence and (when TRAINER_STATS_EN is defined) statistics.
module tb_trainer;

    localparam int unsigned N = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                sample_valid = 1'b0;
    logic [N-1:0][7:0]   sample_data = '0;
    logic [15:0]         sample_target = 16'd0;
    logic                sample_train = 1'b0;
    logic                sample_ready;
    logic                train;
    logic                argument_valid;
    logic [N-1:0][7:0]   argument_data;
    logic                argument_ready = 1'b0;
    logic                result_valid = 1'b0;
    logic [15:0]         result_data = 16'd0;
    logic                result_ready;
    logic                error_valid;
    logic [15:0]         error_data;
    logic                error_ready = 1'b0;
    logic                propagate_valid = 1'b0;
    logic [N-1:0][15:0]  propagate_data = '0;
    logic                propagate_ready;
    logic                done;
`ifdef TRAINER_STATS_EN
    logic [31:0]         stat_count;
    logic [31:0]         stat_abs_error;
`endif

    int     n_cmp = 0;
    int     n_bad = 0;
    longint exp_count = 0;
    longint exp_abs = 0;

    trainer #(.N(N)) dut (
        .clock           (clock),
        .reset           (reset),
        .sample_valid    (sample_valid),
        .sample_data     (sample_data),
        .sample_target   (sample_target),
        .sample_train    (sample_train),
        .sample_ready    (sample_ready),
        .train           (train),
        .argument_valid  (argument_valid),
        .argument_data   (argument_data),
        .argument_ready  (argument_ready),
        .result_valid    (result_valid),
        .result_data     (result_data),
        .result_ready    (result_ready),
        .error_valid     (error_valid),
        .error_data      (error_data),
        .error_ready     (error_ready),
        .propagate_valid (propagate_valid),
        .propagate_data  (propagate_data),
        .propagate_ready (propagate_ready),
        .done            (done)
`ifdef TRAINER_STATS_EN
        ,
        .stat_count      (stat_count),
        .stat_abs_error  (stat_abs_error)
`endif
    );

    always #5 clock = ~clock;

    // {sample_ready, argument_valid, result_ready, error_valid, propagate_ready, done}
    function automatic logic [5:0] hs_vec();
        return {sample_ready, argument_valid, result_ready, error_valid, propagate_ready, done};
    endfunction

    // Reference error: signed difference clamped to 16-bit signed range.
    function automatic int ref_error(input logic [15:0] tgt, input logic [15:0] res);
        int t;
        int r;
        int e;
        t = $signed(tgt);
        r = $signed(res);
        e = t - r;
        if (e > 32767) e = 32767;
        if (e < -32768) e = -32768;
        return e;
    endfunction

    // One complete transaction with the given stall counts on each stage.
    task automatic run_txn(input logic [N-1:0][7:0] args, input logic [15:0] tgt,
                           input logic [15:0] res, input logic trn,
                           input int sa, input int sr, input int se, input int sp);
        int          cyc;
        int          e;
        int          want_cyc;
        logic [15:0] exp_e;
        e     = ref_error(tgt, res);
        exp_e = 16'(e);
        @(negedge clock);
        n_cmp++;
        if (hs_vec() !== 6'b100000) begin
            n_bad++; $display("FAIL idle_hs: got %b want %b", hs_vec(), 6'b100000);
        end
        sample_valid = 1'b1; sample_data = args; sample_target = tgt; sample_train = trn;
        @(negedge clock);
        cyc = 1;
        sample_valid = 1'b0; sample_data = N*8'($urandom); sample_target = 16'($urandom);
        sample_train = ~trn;
        n_cmp++;
        if (hs_vec() !== 6'b010000 || argument_data !== args || train !== trn) begin
            n_bad++; $display("FAIL arg: got hs=%b data=%h train=%b want hs=010000 data=%h train=%b",
                              hs_vec(), argument_data, train, args, trn);
        end
        for (int i = 0; i < sa; i++) begin
            @(negedge clock); cyc++;
            n_cmp++;
            if (hs_vec() !== 6'b010000 || argument_data !== args) begin
                n_bad++; $display("FAIL arg_stall: got hs=%b data=%h want hs=010000 data=%h",
                                  hs_vec(), argument_data, args);
            end
        end
        argument_ready = 1'b1;
        @(negedge clock); cyc++;
        argument_ready = 1'b0;
        for (int i = 0; i <= sr; i++) begin
            if (i > 0) begin
                @(negedge clock); cyc++;
            end
            n_cmp++;
            if (hs_vec() !== 6'b001000 || train !== trn) begin
                n_bad++; $display("FAIL res: got hs=%b train=%b want hs=001000 train=%b",
                                  hs_vec(), train, trn);
            end
        end
        result_valid = 1'b1; result_data = res;
        @(negedge clock); cyc++;
        result_valid = 1'b0; result_data = 16'($urandom);
        exp_abs = exp_abs + ((e < 0) ? -e : e);
        if (exp_abs > 64'hFFFF_FFFF) exp_abs = 64'hFFFF_FFFF;
        if (trn) begin
            for (int i = 0; i <= se; i++) begin
                if (i > 0) begin
                    @(negedge clock); cyc++;
                end
                n_cmp++;
                if (hs_vec() !== 6'b000100 || error_data !== exp_e || train !== 1'b1) begin
                    n_bad++; $display("FAIL err: got hs=%b err=%h train=%b want hs=000100 err=%h train=1",
                                      hs_vec(), error_data, train, exp_e);
                end
            end
            error_ready = 1'b1;
            @(negedge clock); cyc++;
            error_ready = 1'b0;
            for (int i = 0; i <= sp; i++) begin
                if (i > 0) begin
                    @(negedge clock); cyc++;
                end
                n_cmp++;
                if (hs_vec() !== 6'b000010 || train !== 1'b1) begin
                    n_bad++; $display("FAIL prp: got hs=%b train=%b want hs=000010 train=1",
                                      hs_vec(), train);
                end
            end
            propagate_valid = 1'b1; propagate_data = {16'($urandom), 16'($urandom)};
            @(negedge clock); cyc++;
            propagate_valid = 1'b0;
        end
        exp_count = (exp_count + 1) & 64'hFFFF_FFFF;
        want_cyc = trn ? (5 + sa + sr + se + sp) : (3 + sa + sr);
        n_cmp++;
        if (hs_vec() !== 6'b100001 || error_data !== exp_e || cyc != want_cyc || train !== trn) begin
            n_bad++; $display("FAIL done: got hs=%b err=%h cyc=%0d train=%b want hs=100001 err=%h cyc=%0d train=%b",
                              hs_vec(), error_data, cyc, train, exp_e, want_cyc, trn);
        end
`ifdef TRAINER_STATS_EN
        n_cmp++;
        if (stat_count !== 32'(exp_count) || stat_abs_error !== 32'(exp_abs)) begin
            n_bad++; $display("FAIL stats: got cnt=%0d abs=%0d want cnt=%0d abs=%0d",
                              stat_count, stat_abs_error, exp_count, exp_abs);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if (hs_vec() !== 6'b100000 || train !== 1'b0 || argument_data !== '0 || error_data !== 16'd0) begin
            n_bad++; $display("FAIL reset: got hs=%b train=%b arg=%h err=%h want hs=100000 zeros",
                              hs_vec(), train, argument_data, error_data);
        end
`ifdef TRAINER_STATS_EN
        n_cmp++;
        if (stat_count !== 32'd0 || stat_abs_error !== 32'd0) begin
            n_bad++; $display("FAIL reset_stats: got %0d %0d want 0 0", stat_count, stat_abs_error);
        end
`endif
        exp_count = 0; exp_abs = 0;
        reset = 1'b1;
    endtask

    task automatic test_inference();
        run_txn({8'h12, 8'h34}, 16'd100, 16'd40, 1'b0, 0, 0, 0, 0);
        run_txn({8'hA5, 8'h5A}, 16'hFF00, 16'h0100, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic test_training();
        run_txn({8'h01, 8'h02}, 16'h0010, 16'h0030, 1'b1, 0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        run_txn({8'hFF, 8'h00}, 16'h7FFF, 16'h8000, 1'b1, 0, 0, 0, 0);
        run_txn({8'h00, 8'hFF}, 16'h8000, 16'h7FFF, 1'b1, 0, 0, 0, 0);
        run_txn({8'h55, 8'hAA}, 16'h8000, 16'h0001, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        run_txn({8'hC3, 8'h3C}, 16'h1234, 16'h0234, 1'b1, 4, 4, 4, 4);
        run_txn({8'h77, 8'h88}, 16'h0005, 16'h0009, 1'b0, 4, 2, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            logic [15:0] t;
            logic [15:0] r;
            t = 16'($urandom);
            r = 16'($urandom);
            if (i % 6 == 0) t = {1'b0, 15'h7FFF - 15'($urandom_range(0, 3))};
            if (i % 6 == 1) r = {1'b1, 15'($urandom_range(0, 3))};
            run_txn({8'($urandom), 8'($urandom)}, t, r, 1'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        sample_valid = 1'b1; sample_data = {8'h9, 8'h8}; sample_target = 16'd7; sample_train = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0; argument_ready = 1'b1;
        @(negedge clock);
        argument_ready = 1'b0; result_valid = 1'b1; result_data = 16'd3;
        @(negedge clock);
        result_valid = 1'b0;
        n_cmp++;
        if (hs_vec() !== 6'b000100 || error_data !== 16'd4) begin
            n_bad++; $display("FAIL pre_reset: got hs=%b err=%h want 000100 0004", hs_vec(), error_data);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (hs_vec() !== 6'b100000 || train !== 1'b0 || argument_data !== '0 || error_data !== 16'd0) begin
            n_bad++; $display("FAIL async_reset: got hs=%b train=%b arg=%h err=%h want hs=100000 zeros",
                              hs_vec(), train, argument_data, error_data);
        end
`ifdef TRAINER_STATS_EN
        n_cmp++;
        if (stat_count !== 32'd0 || stat_abs_error !== 32'd0) begin
            n_bad++; $display("FAIL async_reset_stats: got %0d %0d want 0 0", stat_count, stat_abs_error);
        end
`endif
        exp_count = 0; exp_abs = 0;
        @(negedge clock);
        reset = 1'b1;
        run_txn({8'h44, 8'h22}, 16'd50, 16'd60, 1'b1, 0, 0, 0, 0);
    endtask

    task automatic test_stats();
        test_reset();
        run_txn({8'h1, 8'h1}, 16'd15, 16'd10, 1'b1, 0, 0, 0, 0);
        run_txn({8'h2, 8'h2}, 16'd3, 16'd10, 1'b1, 1, 0, 1, 0);
        run_txn({8'h3, 8'h3}, 16'd12, 16'd10, 1'b1, 0, 1, 0, 1);
`ifdef TRAINER_STATS_EN
        n_cmp++;
        if (stat_count !== 32'd3 || stat_abs_error !== 32'd14) begin
            n_bad++; $display("FAIL stats_total: got cnt=%0d abs=%0d want cnt=3 abs=14",
                              stat_count, stat_abs_error);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_inference();
        test_training();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_stats();
        @(negedge clock);
        n_cmp++;
        if (hs_vec() !== 6'b100000) begin
            n_bad++; $display("FAIL done_drop: got %b want 100000", hs_vec());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
